dma_axi_w: RTL and testbench

- AXI-4 full master write engine for the DMA datapath; downstream consumer of the read engine's data stream.
- Accepts a native-interface write request (address plus data beats) and issues one INCR burst of dma_len+1 beats.
- Streams the beats on the W channel, then collects the B response and flags error on a non-OKAY response.

---
 rtl/dma_axi_w_pkg.sv | 30 +++
 rtl/dma_axi_w_if.sv | 67 ++++++
 rtl/dma_axi_w.sv | 130 +++++++++++++
 tb/tb_dma_axi_w.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_axi_w_pkg.sv
// Shared AXI-4 widths, constants and FSM state type for the DMA write engine.
package dma_axi_w_pkg;

   localparam int unsigned AXI_ADDR_W  = 32;
   localparam int unsigned AXI_LEN_W   = 8;
   localparam int unsigned AXI_ID_W    = 1;
   localparam int unsigned AXI_SIZE_W  = 3;
   localparam int unsigned AXI_BURST_W = 2;
   localparam int unsigned AXI_LOCK_W  = 1;
   localparam int unsigned AXI_CACHE_W = 4;
   localparam int unsigned AXI_PROT_W  = 3;
   localparam int unsigned AXI_QOS_W   = 4;
   localparam int unsigned AXI_RESP_W  = 2;

   localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [AXI_CACHE_W-1:0] AXI_CACHE_MOD  = 4'b0010;
   localparam logic [AXI_PROT_W-1:0]  AXI_PROT_NSEC  = 3'b010;
   localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_RESP
   } wr_state_t;

   function automatic logic resp_is_okay(input logic [AXI_RESP_W-1:0] resp);
      return resp == AXI_RESP_OKAY;
   endfunction

endpackage

// File: rtl/dma_axi_w_if.sv
// Native write request plus AXI-4 write channels of the DMA write engine.
interface dma_axi_w_if
   import dma_axi_w_pkg::*;
#(
   parameter int unsigned ADDR_W     = AXI_ADDR_W,
   parameter int unsigned DMA_DATA_W = 32
);
   // native side
   logic [AXI_LEN_W-1:0]      dma_len;
   logic                      dma_ready;
   logic                      error;
   logic                      valid;
   logic [ADDR_W-1:0]         addr;
   logic [DMA_DATA_W-1:0]     wdata;
   logic [DMA_DATA_W/8-1:0]   wstrb;
   logic                      ready;
   // AXI AW
   logic [AXI_ID_W-1:0]       m_axi_awid;
   logic [ADDR_W-1:0]         m_axi_awaddr;
   logic [AXI_LEN_W-1:0]      m_axi_awlen;
   logic [AXI_SIZE_W-1:0]     m_axi_awsize;
   logic [AXI_BURST_W-1:0]    m_axi_awburst;
   logic [AXI_LOCK_W-1:0]     m_axi_awlock;
   logic [AXI_CACHE_W-1:0]    m_axi_awcache;
   logic [AXI_PROT_W-1:0]     m_axi_awprot;
   logic [AXI_QOS_W-1:0]      m_axi_awqos;
   logic                      m_axi_awvalid;
   logic                      m_axi_awready;
   // AXI W
   logic [DMA_DATA_W-1:0]     m_axi_wdata;
   logic [DMA_DATA_W/8-1:0]   m_axi_wstrb;
   logic                      m_axi_wlast;
   logic                      m_axi_wvalid;
   logic                      m_axi_wready;
   // AXI B
   logic [AXI_ID_W-1:0]       m_axi_bid;
   logic [AXI_RESP_W-1:0]     m_axi_bresp;
   logic                      m_axi_bvalid;
   logic                      m_axi_bready;

   // write engine side
   modport master (
      input  dma_len, valid, addr, wdata, wstrb,
      output dma_ready, error, ready,
      output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
             m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
      output m_axi_bready
   );

   // requester + interconnect side
   modport slave (
      output dma_len, valid, addr, wdata, wstrb,
      input  dma_ready, error, ready,
      input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
             m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bid, m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready
   );

endinterface

// File: rtl/dma_axi_w.sv
// DMA write engine: one INCR burst of dma_len+1 beats per native request,
// W data passed straight through, B response folded into the error flag.
module dma_axi_w
   import dma_axi_w_pkg::*;
#(
   parameter int unsigned ADDR_W     = AXI_ADDR_W,
   parameter int unsigned DMA_DATA_W = 32
) (
   input logic         clk,
   input logic         rst,
   dma_axi_w_if.master bus
);

   wr_state_t             state_q, state_d;
   logic [AXI_LEN_W-1:0]  cnt_q, cnt_d;
   logic [AXI_LEN_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  awvalid_q, awvalid_d;
   logic                  aw_done_q, aw_done_d;
   logic                  error_q, error_d;
   logic                  dma_ready_q, dma_ready_d;

   logic                  ready_c, wvalid_c, wlast_c, bready_c;
   logic                  unused_bid;

   assign unused_bid = ^bus.m_axi_bid;

   // State and datapath registers, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         addr_q      <= '0;
         awvalid_q   <= 1'b0;
         aw_done_q   <= 1'b0;
         error_q     <= 1'b0;
         dma_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         awvalid_q   <= awvalid_d;
         aw_done_q   <= aw_done_d;
         error_q     <= error_d;
         dma_ready_q <= dma_ready_d;
      end
   end

   // Next-state logic and combinational handshake outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      addr_d      = addr_q;
      awvalid_d   = awvalid_q;
      aw_done_d   = aw_done_q;
      error_d     = error_q;
      dma_ready_d = dma_ready_q;
      ready_c     = 1'b0;
      wvalid_c    = 1'b0;
      wlast_c     = 1'b0;
      bready_c    = 1'b0;

      // AW runs independently of the W/B sequencing.
      if (awvalid_q && bus.m_axi_awready) begin
         awvalid_d = 1'b0;
         aw_done_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            cnt_d  = '0;
            addr_d = bus.addr;
            len_d  = bus.dma_len;
            if (bus.valid) begin
               state_d     = ST_DATA;
               awvalid_d   = 1'b1;
               dma_ready_d = 1'b0;
            end
         end
         ST_DATA: begin
            wvalid_c = bus.valid;
            ready_c  = bus.m_axi_wready;
            wlast_c  = (cnt_q == len_q);
            if (bus.valid && bus.m_axi_wready) begin
               // compare-before-increment lets len=255 run 256 beats
               cnt_d = cnt_q + AXI_LEN_W'(1);
               if (cnt_q == len_q) begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            bready_c = aw_done_q;
            if (bus.m_axi_bvalid && aw_done_q) begin
               error_d     = !resp_is_okay(bus.m_axi_bresp);
               state_d     = ST_IDLE;
               dma_ready_d = 1'b1;
               aw_done_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.dma_ready     = dma_ready_q;
   assign bus.error         = error_q;
   assign bus.ready         = ready_c;

   assign bus.m_axi_awid    = '0;
   assign bus.m_axi_awaddr  = addr_q;
   assign bus.m_axi_awlen   = len_q;
   assign bus.m_axi_awsize  = AXI_SIZE_W'($clog2(DMA_DATA_W/8));
   assign bus.m_axi_awburst = AXI_BURST_INCR;
   assign bus.m_axi_awlock  = '0;
   assign bus.m_axi_awcache = AXI_CACHE_MOD;
   assign bus.m_axi_awprot  = AXI_PROT_NSEC;
   assign bus.m_axi_awqos   = '0;
   assign bus.m_axi_awvalid = awvalid_q;

   assign bus.m_axi_wdata   = bus.wdata;
   assign bus.m_axi_wstrb   = bus.wstrb;
   assign bus.m_axi_wlast   = wlast_c;
   assign bus.m_axi_wvalid  = wvalid_c;

   assign bus.m_axi_bready  = bready_c;

endmodule

// File: tb/tb_dma_axi_w.sv
// Self-checking bench for dma_axi_w: directed burst table, randomized bursts,
// and a hand-written mid-burst reset sequence.
module tb_dma_axi_w;
   import dma_axi_w_pkg::*;

   localparam int unsigned ADDR_W = AXI_ADDR_W;
   localparam int unsigned DATA_W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dma_axi_w_if #(.ADDR_W(ADDR_W), .DMA_DATA_W(DATA_W)) bus ();

   dma_axi_w #(.ADDR_W(ADDR_W), .DMA_DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0]  len;
      logic [31:0] addr;
      int unsigned aw_delay;   // first cycle (from request cycle) with awready=1
      int unsigned wr_mode;    // 0: wready=1, 1: 1,0,0 pattern, 2: random
      int unsigned valid_pct;
      logic [31:0] data_base;
      logic [3:0]  strb;
      logic [1:0]  bresp;
      bit          exp_err;
      int unsigned exp_beats;
   } vec_t;

   int tests = 0;
   int fails = 0;
   bit prev_err_m = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_burst(input vec_t v);
      logic [31:0] d[$];
      int unsigned n;
      int unsigned beats;
      int unsigned dut_beats;
      int unsigned dut_lasts;
      int unsigned cyc;
      bit aw_m, bdone, in_data, in_resp, aw_now, beat_now, b_now;
      n = int'(v.len) + 1;
      beats = 0; dut_beats = 0; dut_lasts = 0; cyc = 0;
      aw_m = 1'b0; bdone = 1'b0;
      for (int unsigned i = 0; i < n; i++) d.push_back(v.data_base + i * 32'h0101_0101);
      while (!bdone && cyc < 3000) begin
         if (cyc == 0) begin
            bus.valid   = 1'b1;
            bus.addr    = v.addr;
            bus.dma_len = v.len;
         end else begin
            bus.addr    = $urandom;
            bus.dma_len = 8'($urandom);
            bus.valid   = (beats < n) ? ($urandom_range(99) < v.valid_pct) : 1'b0;
         end
         bus.wdata = (beats < n) ? d[beats] : $urandom;
         bus.wstrb = v.strb;
         case (v.wr_mode)
            0:       bus.m_axi_wready = 1'b1;
            1:       bus.m_axi_wready = ((cyc % 3) == 1);
            default: bus.m_axi_wready = 1'($urandom_range(1));
         endcase
         bus.m_axi_awready = (cyc >= v.aw_delay);
         bus.m_axi_bvalid  = (beats == n);
         bus.m_axi_bresp   = v.bresp;
         bus.m_axi_bid     = 1'($urandom_range(1));
         #1;
         in_data = (cyc > 0) && (beats < n);
         in_resp = (cyc > 0) && (beats == n);
         chk("dma_ready", bus.dma_ready, cyc == 0);
         chk("awvalid", bus.m_axi_awvalid, (cyc > 0) && !aw_m);
         chk("wvalid", bus.m_axi_wvalid, in_data && bus.valid);
         chk("ready", bus.ready, in_data && bus.m_axi_wready);
         chk("wlast", bus.m_axi_wlast, in_data && (beats == n - 1));
         chk("bready", bus.m_axi_bready, in_resp && aw_m);
         chk("error_hold", bus.error, prev_err_m);
         if (in_data && bus.valid) begin
            chk("wdata", bus.m_axi_wdata, d[beats]);
            chk("wstrb", bus.m_axi_wstrb, v.strb);
         end
         aw_now = (cyc > 0) && !aw_m && bus.m_axi_awready;
         if (aw_now) begin
            chk("awaddr", bus.m_axi_awaddr, v.addr);
            chk("awlen", bus.m_axi_awlen, v.len);
            chk("awsize", bus.m_axi_awsize, 2);
            chk("awburst", bus.m_axi_awburst, 1);
            chk("awcache", bus.m_axi_awcache, 2);
            chk("awprot", bus.m_axi_awprot, 2);
            chk("awid_lock_qos", {bus.m_axi_awid, bus.m_axi_awlock, bus.m_axi_awqos}, 0);
         end
         if (bus.m_axi_wvalid && bus.ready) begin
            dut_beats++;
            if (bus.m_axi_wlast) dut_lasts++;
         end
         beat_now = in_data && bus.valid && bus.m_axi_wready;
         b_now    = in_resp && aw_m && bus.m_axi_bvalid;
         @(posedge clk);
         #1;
         if (aw_now) aw_m = 1'b1;
         if (beat_now) beats++;
         if (b_now) begin
            bdone = 1'b1;
            prev_err_m = (v.bresp != 2'b00);
            chk("error_after_b", bus.error, v.exp_err);
            chk("dma_ready_after_b", bus.dma_ready, 1);
         end
         cyc++;
      end
      bus.valid = 1'b0;
      bus.m_axi_bvalid = 1'b0;
      chk("b_handshake_done", bdone, 1);
      chk("beats_accepted", dut_beats, v.exp_beats);
      chk("wlast_count", dut_lasts, 1);
      if (!bdone) begin
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
         prev_err_m = 1'b0;
      end
   endtask

   vec_t tbl[8];
   vec_t rv;

   initial begin
      rst = 1'b1;
      bus.valid = 1'b0; bus.addr = '0; bus.dma_len = '0; bus.wdata = '0; bus.wstrb = '0;
      bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
      bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = '0; bus.m_axi_bid = '0;

      //          len    addr          awd wm vp   data_base     strb  bresp err beats
      tbl[0] = '{8'd3,   32'h0000_1000, 0, 0, 100, 32'h1111_0000, 4'hF, 2'b00, 0, 4};
      tbl[1] = '{8'd0,   32'h0000_2000, 0, 0, 100, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 1};
      tbl[2] = '{8'd1,   32'h0000_3000, 6, 0, 100, 32'h2222_0000, 4'h3, 2'b00, 0, 2};
      tbl[3] = '{8'd7,   32'h0000_4000, 0, 1, 100, 32'h3333_0000, 4'hA, 2'b00, 0, 8};
      tbl[4] = '{8'd2,   32'h0000_5000, 1, 0, 100, 32'h4444_0000, 4'hF, 2'b10, 1, 3};
      tbl[5] = '{8'd2,   32'h0000_6000, 3, 0,  70, 32'h5555_0000, 4'h5, 2'b00, 0, 3};
      tbl[6] = '{8'd1,   32'h0000_7000, 2, 0, 100, 32'h6666_0000, 4'hC, 2'b11, 1, 2};
      tbl[7] = '{8'd255, 32'h0001_0000, 4, 0, 100, 32'h7777_0000, 4'hF, 2'b00, 0, 256};

      #1;
      chk("rst_dma_ready", bus.dma_ready, 1);
      chk("rst_error", bus.error, 0);
      chk("rst_awvalid", bus.m_axi_awvalid, 0);
      chk("rst_comb_outs", {bus.ready, bus.m_axi_wvalid, bus.m_axi_wlast, bus.m_axi_bready}, 0);
      chk("rst_awaddr_awlen", {bus.m_axi_awaddr, bus.m_axi_awlen}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) run_burst(tbl[i]);

      for (int i = 0; i < 30; i++) begin
         rv.len       = ($urandom_range(9) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(7));
         rv.addr      = $urandom & 32'hFFFF_FFFC;
         rv.aw_delay  = $urandom_range(10);
         rv.wr_mode   = $urandom_range(2);
         rv.valid_pct = $urandom_range(100, 50);
         rv.data_base = $urandom;
         rv.strb      = 4'($urandom);
         rv.bresp     = 2'($urandom);
         rv.exp_err   = (rv.bresp != 2'b00);
         rv.exp_beats = int'(rv.len) + 1;
         run_burst(rv);
      end

      // mid-burst reset: leave error=1 first so the reset clearing it is visible
      run_burst(tbl[4]);
      bus.valid = 1'b1; bus.addr = 32'h0000_8000; bus.dma_len = 8'd7;
      bus.wdata = 32'hAAAA_0000; bus.wstrb = 4'hF;
      bus.m_axi_wready = 1'b1; bus.m_axi_awready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_beat3_ready", bus.ready, 1);
      rst = 1'b1;
      #1;
      chk("midrst_awvalid", bus.m_axi_awvalid, 0);
      chk("midrst_dma_ready", bus.dma_ready, 1);
      chk("midrst_error", bus.error, 0);
      chk("midrst_comb_outs", {bus.ready, bus.m_axi_wvalid, bus.m_axi_wlast, bus.m_axi_bready}, 0);
      bus.valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      prev_err_m = 1'b0;
      @(posedge clk);
      #1;
      rv = '{8'd1, 32'h0000_9000, 1, 0, 100, 32'h9999_0000, 4'hF, 2'b00, 0, 2};
      run_burst(rv);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
